// File: rtl/rt_pixel_scan.sv
`default_nettype none
// ============================================================================
// Module   : rt_pixel_scan
// Purpose  : Raster-order pixel coordinate generator feeding rt_rgu. Walks a
//            runtime-sized image pixel by pixel and streams each pixel's
//            coordinates as signed fixed-point values on a valid/ready
//            interface, together with integer indices and a last flag for
//            the downstream framebuffer writer.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, abort        - frame request (IDLE only) / frame cancel
//            img_width/height    - frame size, sampled on an accepted start
//            busy, done          - RUN indicator / one-cycle completion pulse
//            out_valid/ready     - coordinate stream handshake
//            out_x, out_y        - fixed-point coordinates (IW.QW)
//            out_px_x, out_px_y  - integer column / row
//            out_last            - final pixel of the frame
// Options  : RT_PIXEL_CENTER_EN  - when defined, out_x/out_y carry a
//                                  half-pixel offset (rays through centres)
// Revision : 1.0 - initial release
// ============================================================================
module rt_pixel_scan #(
    parameter int CAMERA_IW = 8,
    parameter int CAMERA_QW = 8,
    parameter int CAMERA_WL = CAMERA_IW + CAMERA_QW,
    parameter int CNT_W     = 12,
    parameter int MAX_DIM   = 2**(CAMERA_IW-1) - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     img_width,
    input  logic [CNT_W-1:0]     img_height,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CAMERA_WL-1:0] out_x,
    output logic [CAMERA_WL-1:0] out_y,
    output logic [CNT_W-1:0]     out_px_x,
    output logic [CNT_W-1:0]     out_px_y,
    output logic                 out_last
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Dimensions are clamped so every coordinate fits the signed integer
    // field without touching its sign bit.
    localparam logic [CNT_W-1:0] DIM_LIM = CNT_W'(MAX_DIM + 1);

`ifdef RT_PIXEL_CENTER_EN
    localparam logic [CAMERA_QW-1:0] FRAC_OFS = {1'b1, {(CAMERA_QW-1){1'b0}}};
`else
    localparam logic [CAMERA_QW-1:0] FRAC_OFS = '0;
`endif

    function automatic logic [CNT_W-1:0] clamp_dim(input logic [CNT_W-1:0] d);
        return (d > DIM_LIM) ? DIM_LIM : d;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] px_x_q, px_x_d;
    logic [CNT_W-1:0] px_y_q, px_y_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] h_q, h_d;
    // Set for an empty frame: DONE is held one extra cycle before pulsing so
    // the pulse lands two cycles after start.
    logic             hold_q, hold_d;

    logic             w_xfer;
    logic             w_eol;
    logic             w_last;
    logic [CNT_W-1:0] w_start_w;
    logic [CNT_W-1:0] w_start_h;

    assign w_xfer    = (state_q == ST_RUN) && out_ready;
    assign w_eol     = (px_x_q == w_q - CNT_W'(1));
    assign w_last    = w_eol && (px_y_q == h_q - CNT_W'(1));
    assign w_start_w = clamp_dim(img_width);
    assign w_start_h = clamp_dim(img_height);

    always_comb begin
        state_d = state_q;
        px_x_d  = px_x_q;
        px_y_d  = px_y_q;
        w_d     = w_q;
        h_d     = h_q;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE: begin
                // abort outranks start while idle
                if (start && !abort) begin
                    w_d    = w_start_w;
                    h_d    = w_start_h;
                    px_x_d = '0;
                    px_y_d = '0;
                    if ((w_start_w == '0) || (w_start_h == '0)) begin
                        state_d = ST_DONE;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    px_x_d  = '0;
                    px_y_d  = '0;
                end else if (w_xfer) begin
                    if (w_last) begin
                        state_d = ST_DONE;
                    end else if (w_eol) begin
                        px_x_d = '0;
                        px_y_d = px_y_q + CNT_W'(1);
                    end else begin
                        px_x_d = px_x_q + CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                hold_d = 1'b0;
                if (abort || !hold_q) begin
                    state_d = ST_IDLE;
                    px_x_d  = '0;
                    px_y_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                hold_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            px_x_q  <= '0;
            px_y_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_x_q  <= px_x_d;
            px_y_q  <= px_y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            hold_q  <= hold_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_RUN);
    assign out_last  = (state_q == ST_RUN) && w_last;
    // An abort landing on the pulse cycle suppresses the pulse.
    assign done      = (state_q == ST_DONE) && !hold_q && !abort;
    assign out_px_x  = px_x_q;
    assign out_px_y  = px_y_q;
    // The clamp keeps px below 2**(IW-1), so the low IW bits are the whole
    // value and the sign bit is always clear.
    assign out_x     = CAMERA_WL'({px_x_q[CAMERA_IW-1:0], FRAC_OFS});
    assign out_y     = CAMERA_WL'({px_y_q[CAMERA_IW-1:0], FRAC_OFS});

endmodule
`default_nettype wire

// File: tb/tb_rt_pixel_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_rt_pixel_scan
// Purpose  : Directed self-checking bench for rt_pixel_scan (default
//            parameters: IW=8, QW=8, CNT_W=12, MAX_DIM=127).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rt_pixel_scan;

    localparam int CNT_W = 12;
    localparam int WL    = 16;
`ifdef RT_PIXEL_CENTER_EN
    localparam int FRAC  = 128;
`else
    localparam int FRAC  = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] img_width = '0;
    logic [CNT_W-1:0] img_height = '0;
    logic             busy;
    logic             done;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WL-1:0]    out_x;
    logic [WL-1:0]    out_y;
    logic [CNT_W-1:0] out_px_x;
    logic [CNT_W-1:0] out_px_y;
    logic             out_last;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rt_pixel_scan dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .img_width  (img_width),
        .img_height (img_height),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_px_x   (out_px_x),
        .out_px_y   (out_px_y),
        .out_last   (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fx(input int p);
        return 32'((p << 8) + FRAC);
    endfunction

    // Check a valid beat at integer position (x,y).
    task automatic chk_beat(input string tag, input int x, input int y, input logic last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_px_x"},  32'(out_px_x),  32'(x));
        chk({tag, "_px_y"},  32'(out_px_y),  32'(y));
        chk({tag, "_x"},     32'(out_x),     fx(x));
        chk({tag, "_y"},     32'(out_y),     fx(y));
        chk({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    initial begin
        int e;
        int dn;
        logic [3:0] pat;

        // ---------------- reset state
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_x",     32'(out_x), 0);
        chk("rst_px_x",  32'(out_px_x), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- 3x2 frame, ready held high
        @(negedge clk);
        img_width = 3; img_height = 2; start = 1; out_ready = 1;
        #1 chk("t1_c0_valid", 32'(out_valid), 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            // a start while running must be ignored
            start = (c == 3);
            img_width = (c == 3) ? 12'd7 : 12'd3;
            #1;
            chk("t1_busy", 32'(busy), 1);
            chk_beat("t1", (c-1) % 3, (c-1) / 3, c == 6);
        end
        @(negedge clk);
        start = 0;
        #1;
        chk("t1_c7_valid", 32'(out_valid), 0);
        chk("t1_c7_done",  32'(done), 1);
        chk("t1_c7_busy",  32'(busy), 0);
        @(negedge clk);
        #1 chk("t1_c8_done", 32'(done), 0);

        // ---------------- same frame with ready pattern 1,0,0,1
        @(negedge clk);
        img_width = 3; img_height = 2; start = 1;
        e = 0; dn = 0; pat = 4'b1001;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start = 0;
            out_ready = pat[c % 4];
            #1;
            if (out_valid) begin
                chk_beat("t2", e % 3, e / 3, e == 5);
                if (out_ready) e++;
            end
            if (done) dn++;
        end
        chk("t2_transfers", 32'(e), 6);
        chk("t2_done_count", 32'(dn), 1);
        out_ready = 1;

        // ---------------- empty frame W=0
        @(negedge clk);
        img_width = 0; img_height = 5; start = 1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 0;
            #1;
            chk("t3_valid", 32'(out_valid), 0);
            chk("t3_done",  32'(done), 32'(c == 2));
        end

        // ---------------- abort beats start in IDLE
        @(negedge clk);
        img_width = 4; img_height = 4; start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        #1;
        chk("t4_idle_abort_valid", 32'(out_valid), 0);
        chk("t4_idle_abort_busy",  32'(busy), 0);

        // ---------------- 4x4, abort with the 5th transfer
        @(negedge clk);
        start = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 0;
            abort = (c == 5);
            #1 chk_beat("t4", (c-1) % 4, (c-1) / 4, 1'b0);
        end
        @(negedge clk);
        abort = 0;
        #1;
        chk("t4_abort_valid", 32'(out_valid), 0);
        chk("t4_abort_busy",  32'(busy), 0);
        chk("t4_abort_done",  32'(done), 0);
        @(negedge clk);
        #1 chk("t4_abort_done2", 32'(done), 0);

        // ---------------- restart, then reset mid-frame at (2,1)
        @(negedge clk);
        start = 1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 0;
            #1 chk_beat("t5", (c-1) % 4, (c-1) / 4, 1'b0);
        end
        rst_n = 0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_busy",  32'(busy), 0);
        chk("t5_rst_px_x",  32'(out_px_x), 0);
        chk("t5_rst_px_y",  32'(out_px_y), 0);
        chk("t5_rst_x",     32'(out_x), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        img_width = 3; img_height = 2; start = 1;
        @(negedge clk);
        start = 0;
        #1 chk_beat("t5_first", 0, 0, 1'b0);
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (done) dn++;
        end
        chk("t5_done_count", 32'(dn), 1);

        // ---------------- clamp: width 4095 -> 128 columns
        @(negedge clk);
        img_width = 12'd4095; img_height = 1; start = 1;
        for (int c = 1; c <= 128; c++) begin
            @(negedge clk);
            start = 0;
            #1;
            if (c >= 127) chk_beat("t6", c - 1, 0, c == 128);
        end
        @(negedge clk);
        #1;
        chk("t6_done",  32'(done), 1);
        chk("t6_valid", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
